// File: rtl/peripheral_input_debouncer.sv
// rtl/peripheral_input_debouncer.sv - pin synchronizer, debouncer and sticky rising-edge flags
//
// Purpose:
//   Front end between raw asynchronous pins and the peripheral block.
//   Each pin is synchronized with two flops and then debounced. The
//   debounced level is driven out on stable_inputs. A sticky flag is set
//   on every debounced 0 -> 1 transition. The CPU reads the levels and
//   the flags over the data-memory bus and clears flags by writing 1s.
//
// Ports:
//   clock          system clock; all state updates on the rising edge
//   reset_n        asynchronous active-low reset
//   raw_inputs     unsynchronized pin levels
//                  (bit 0 = port 25, 1 = port 26, 2 = button 1, 3 = button 2)
//   address        bus address; only address[2] is decoded
//                  (0 = levels, 1 = flags)
//   input_data     bus write data; [WIDTH-1:0] is the write-1-to-clear mask
//   should_write   bus write strobe
//   output_data    combinational bus read data
//   stable_inputs  debounced levels, to the peripheral block's input_peripherals
//   edge_pending   high while any rising-edge flag is set

module peripheral_input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNTER_WIDTH   = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  raw_inputs,
  input  logic [31:0]       address,
  input  logic [31:0]       input_data,
  input  logic              should_write,
  output logic [31:0]       output_data,
  output logic [WIDTH-1:0]  stable_inputs,
  output logic              edge_pending
);

  localparam logic [COUNTER_WIDTH-1:0] COUNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]         sync1;
  logic [WIDTH-1:0]         sync2;
  logic [WIDTH-1:0]         stable_next;
  logic [WIDTH-1:0]         flags;
  logic [WIDTH-1:0]         flags_next;
  logic [WIDTH-1:0]         clear_mask;
  logic [WIDTH-1:0]         rise;
  logic [COUNTER_WIDTH-1:0] counter      [WIDTH];
  logic [COUNTER_WIDTH-1:0] counter_next [WIDTH];
  logic                     flag_select;
  logic                     unused_bus_bits;

  assign flag_select     = address[2];
  assign unused_bus_bits = ^{address[31:3], address[1:0], input_data[31:WIDTH]};

  // The counter tracks how many consecutive cycles sync2 has disagreed with
  // the accepted level; any agreement restarts it from zero.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stable_next[i]  = stable_inputs[i];
      counter_next[i] = '0;
      if (sync2[i] != stable_inputs[i]) begin
        if (counter[i] == COUNT_LAST) begin
          stable_next[i] = sync2[i];
        end else begin
          counter_next[i] = counter[i] + COUNTER_WIDTH'(1);
        end
      end
    end
  end

  // Set is applied after clear so an edge coinciding with a clear of the
  // same bit is never lost.
  always_comb begin
    rise       = stable_next & ~stable_inputs;
    clear_mask = (should_write && flag_select) ? input_data[WIDTH-1:0] : '0;
    flags_next = (flags & ~clear_mask) | rise;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1         <= '0;
      sync2         <= '0;
      stable_inputs <= '0;
      flags         <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        counter[i] <= '0;
      end
    end else begin
      sync1         <= raw_inputs;
      sync2         <= sync1;
      stable_inputs <= stable_next;
      flags         <= flags_next;
      for (int i = 0; i < WIDTH; i++) begin
        counter[i] <= counter_next[i];
      end
    end
  end

  always_comb begin
    output_data = flag_select ? 32'(flags) : 32'(stable_inputs);
  end

  assign edge_pending = |flags;

endmodule
